// File: rtl/greyscale_pkg.sv
// Shared definitions for the RGB-to-grey pipeline: mode encodings,
// base coefficient sets and the helper that scales them to COEF_W.
package greyscale_pkg;

  typedef enum logic [1:0] {
    MODE_PROG = 2'd0,
    MODE_709  = 2'd1,
    MODE_AVG  = 2'd2,
    MODE_BYP  = 2'd3
  } grey_mode_e;

  // Base weights expressed with 8 fractional bits.
  localparam logic [7:0] COEF_709_R  = 8'd54;
  localparam logic [7:0] COEF_709_G  = 8'd183;
  localparam logic [7:0] COEF_709_B  = 8'd19;
  localparam logic [7:0] COEF_AVG    = 8'd85;
  localparam logic [7:0] COEF_PROG_R = 8'd77;
  localparam logic [7:0] COEF_PROG_G = 8'd150;
  localparam logic [7:0] COEF_PROG_B = 8'd29;

  // Index 0 = red, 1 = green, 2 = blue; wide enough for any COEF_W up to 32.
  typedef logic [2:0][31:0] coef_set_t;

  // Fixed weight triplet for a mode, rescaled from 8 to coef_w fractional bits.
  // MODE_PROG returns the recommended power-up programmable set; bypass has none.
  function automatic coef_set_t mode_coefs(input grey_mode_e m, input int unsigned coef_w);
    coef_set_t   c;
    int unsigned sh;
    sh = coef_w - 8;
    c  = '0;
    case (m)
      MODE_709: begin
        c[0] = 32'(COEF_709_R) << sh;
        c[1] = 32'(COEF_709_G) << sh;
        c[2] = 32'(COEF_709_B) << sh;
      end
      MODE_AVG: begin
        c[0] = 32'(COEF_AVG) << sh;
        c[1] = 32'(COEF_AVG) << sh;
        c[2] = 32'(COEF_AVG) << sh;
      end
      MODE_PROG: begin
        c[0] = 32'(COEF_PROG_R) << sh;
        c[1] = 32'(COEF_PROG_G) << sh;
        c[2] = 32'(COEF_PROG_B) << sh;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/grey_mac.sv
// Combinational weighted sum of three channels with optional half-LSB
// rounding, fixed-point rescale and clamp to the output range.
module grey_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ROUND  = 1
) (
  input  logic [DATA_W-1:0] r,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] b,
  input  logic [COEF_W-1:0] coef_r,
  input  logic [COEF_W-1:0] coef_g,
  input  logic [COEF_W-1:0] coef_b,
  input  logic              bypass,
  output logic [DATA_W-1:0] grey
);

  localparam int PROD_W = DATA_W + COEF_W;
  // Two guard bits hold the sum of three full-scale products plus rounding.
  localparam int SUM_W  = PROD_W + 2;
  localparam logic [SUM_W-1:0] HALF =
    (ROUND != 0) ? (SUM_W'(1) << (COEF_W - 1)) : '0;
  localparam logic [SUM_W-1:0] GREY_MAX =
    {{(SUM_W - DATA_W){1'b0}}, {DATA_W{1'b1}}};

  logic [DATA_W-1:0] chan [3];
  logic [COEF_W-1:0] coef [3];
  logic [PROD_W-1:0] prod [3];
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  scaled;

  assign chan[0] = r;
  assign chan[1] = g;
  assign chan[2] = b;
  assign coef[0] = coef_r;
  assign coef[1] = coef_g;
  assign coef[2] = coef_b;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_prod
      assign prod[gi] = {{COEF_W{1'b0}}, chan[gi]} * {{DATA_W{1'b0}}, coef[gi]};
    end
  endgenerate

  assign sum    = {2'b00, prod[0]} + {2'b00, prod[1]} + {2'b00, prod[2]} + HALF;
  assign scaled = sum >> COEF_W;

  // Bypass forwards green untouched; otherwise clamp instead of wrapping.
  always_comb begin
    if (bypass)
      grey = g;
    else if (scaled > GREY_MAX)
      grey = '1;
    else
      grey = scaled[DATA_W-1:0];
  end

endmodule

// File: rtl/greyscale_pipe.sv
// Two-stage RGB-to-grey converter with valid/ready flow control.
// S1 latches the pixel with the weights chosen at accept time, the MAC
// sits between S1 and S2, and S2 holds the registered result.
module greyscale_pipe
  import greyscale_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int SB_W   = 2,
  parameter int ROUND  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
  input  logic [SB_W-1:0]   in_sb,
  input  logic [1:0]        mode,
  input  logic [COEF_W-1:0] coef_r,
  input  logic [COEF_W-1:0] coef_g,
  input  logic [COEF_W-1:0] coef_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_grey,
  output logic [SB_W-1:0]   out_sb
);

  // Fixed weight tables resolved at elaboration for this COEF_W.
  localparam coef_set_t SET_709 = mode_coefs(MODE_709, COEF_W);
  localparam coef_set_t SET_AVG = mode_coefs(MODE_AVG, COEF_W);

  logic [DATA_W-1:0] chan_in   [3];
  logic [COEF_W-1:0] coef_prog [3];
  logic [COEF_W-1:0] coef_sel  [3];

  logic              v1_reg;
  logic              byp1_reg;
  logic [SB_W-1:0]   sb1_reg;
  logic [DATA_W-1:0] chan1_reg [3];
  logic [COEF_W-1:0] coef1_reg [3];

  logic              v2_reg;
  logic [DATA_W-1:0] grey2_reg;
  logic [SB_W-1:0]   sb2_reg;

  logic              en1;
  logic              en2;
  logic [DATA_W-1:0] grey_next;

  // A stage may load when it is empty or its successor is moving.
  assign en2      = out_ready | ~v2_reg;
  assign en1      = en2 | ~v1_reg;
  assign in_ready = en1;

  assign chan_in[0]   = in_r;
  assign chan_in[1]   = in_g;
  assign chan_in[2]   = in_b;
  assign coef_prog[0] = coef_r;
  assign coef_prog[1] = coef_g;
  assign coef_prog[2] = coef_b;

  // Weight per channel for the pixel being offered, by its own mode.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_coef
      assign coef_sel[gi] =
        (mode == MODE_709) ? SET_709[gi][COEF_W-1:0] :
        (mode == MODE_AVG) ? SET_AVG[gi][COEF_W-1:0] :
        (mode == MODE_BYP) ? '0 :
                             coef_prog[gi];
    end
  endgenerate

  // S1: capture pixel, sideband and its weights; hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg   <= 1'b0;
      byp1_reg <= 1'b0;
      sb1_reg  <= '0;
      for (int i = 0; i < 3; i++) begin
        chan1_reg[i] <= '0;
        coef1_reg[i] <= '0;
      end
    end else if (en1) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        byp1_reg <= (mode == MODE_BYP);
        sb1_reg  <= in_sb;
        for (int i = 0; i < 3; i++) begin
          chan1_reg[i] <= chan_in[i];
          coef1_reg[i] <= coef_sel[i];
        end
      end
    end
  end

  grey_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ROUND  (ROUND)
  ) u_mac (
    .r      (chan1_reg[0]),
    .g      (chan1_reg[1]),
    .b      (chan1_reg[2]),
    .coef_r (coef1_reg[0]),
    .coef_g (coef1_reg[1]),
    .coef_b (coef1_reg[2]),
    .bypass (byp1_reg),
    .grey   (grey_next)
  );

  // S2: register the finished sample with its sideband; hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg    <= 1'b0;
      grey2_reg <= '0;
      sb2_reg   <= '0;
    end else if (en2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        grey2_reg <= grey_next;
        sb2_reg   <= sb1_reg;
      end
    end
  end

  assign out_valid = v2_reg;
  assign out_grey  = grey2_reg;
  assign out_sb    = sb2_reg;

endmodule

// File: tb/tb_greyscale_pipe.sv
// Directed bench for greyscale_pipe: vector table plus streaming,
// back-pressure, mid-stream mode change and asynchronous reset sequences.
module tb_greyscale_pipe;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int SB_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_r = '0;
  logic [DATA_W-1:0] in_g = '0;
  logic [DATA_W-1:0] in_b = '0;
  logic [SB_W-1:0]   in_sb = '0;
  logic [1:0]        mode = '0;
  logic [COEF_W-1:0] coef_r = '0;
  logic [COEF_W-1:0] coef_g = '0;
  logic [COEF_W-1:0] coef_b = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_grey;
  logic [SB_W-1:0]   out_sb;

  int n_tests = 0;
  int n_fail  = 0;

  greyscale_pipe #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .SB_W   (SB_W),
    .ROUND  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .in_sb     (in_sb),
    .mode      (mode),
    .coef_r    (coef_r),
    .coef_g    (coef_g),
    .coef_b    (coef_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_grey  (out_grey),
    .out_sb    (out_sb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int cr;
    int cg;
    int cb;
    int r;
    int g;
    int b;
    int sb;
    int exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference luminance: round-to-nearest, clamp to 255.
  function automatic int model(input int m, input int cr, input int cg, input int cb,
                               input int r, input int g, input int b);
    int wr, wg, wb, s;
    wr = cr; wg = cg; wb = cb;
    if (m == 3) return g;
    if (m == 1) begin wr = 54; wg = 183; wb = 19; end
    if (m == 2) begin wr = 85; wg = 85;  wb = 85; end
    s = (r * wr + g * wg + b * wb + 128) / 256;
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int pix_r(input int i); return (i * 37 + 11) % 256; endfunction
  function automatic int pix_g(input int i); return (i * 53 + 7) % 256;  endfunction
  function automatic int pix_b(input int i); return (i * 91 + 3) % 256;  endfunction

  // One isolated pixel: check acceptance, latency 2, value and sideband.
  task automatic apply_one(input int idx, input vec_t v);
    int lat;
    bit seen;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mode      = 2'(v.mode);
    coef_r    = 8'(v.cr);
    coef_g    = 8'(v.cg);
    coef_b    = 8'(v.cb);
    in_r      = 8'(v.r);
    in_g      = 8'(v.g);
    in_b      = 8'(v.b);
    in_sb     = 2'(v.sb);
    @(negedge clk);
    check($sformatf("vec%0d_in_ready", idx), int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check($sformatf("vec%0d_latency", idx), seen ? lat : -1, 2);
    if (seen) begin
      check($sformatf("vec%0d_grey", idx), int'(out_grey), v.exp);
      check($sformatf("vec%0d_sb", idx), int'(out_sb), v.sb);
    end
    $display("[TB] vec %0d mode %0d rgb (%0d,%0d,%0d) grey %0d sb %0d lat %0d",
             idx, v.mode, v.r, v.g, v.b, int'(out_grey), int'(out_sb), lat);
  endtask

  // Continuous stream of n pixels; optional out_ready pattern 1,0,0,1 and a
  // switch from mode 0 to BT.709 starting at pixel switch_at.
  task automatic run_stream(input string tag, input int n, input bit toggle, input int switch_at);
    int sent, got, occ, cyc, e_grey, e_sb;
    int exp_grey [$];
    int exp_sb [$];
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    sent = 0; got = 0; occ = 0; cyc = 0;
    while (got < n && cyc < 300) begin
      @(posedge clk); #1;
      out_ready = toggle ? pat[cyc % 4] : 1'b1;
      if (sent < n) begin
        in_valid = 1'b1;
        mode     = (sent >= switch_at) ? 2'd1 : 2'd0;
        coef_r   = 8'd77;
        coef_g   = 8'd150;
        coef_b   = 8'd29;
        in_r     = 8'(pix_r(sent));
        in_g     = 8'(pix_g(sent));
        in_b     = 8'(pix_b(sent));
        in_sb    = {sent == n - 1, sent == 0};
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check({tag, "_in_ready"}, int'(in_ready), (occ == 2 && !out_ready) ? 0 : 1);
      if (out_valid && out_ready) begin
        if (exp_grey.size() == 0) begin
          check({tag, "_extra_output"}, 1, 0);
        end else begin
          e_grey = exp_grey.pop_front();
          e_sb   = exp_sb.pop_front();
          check($sformatf("%s_grey%0d", tag, got), int'(out_grey), e_grey);
          check($sformatf("%s_sb%0d", tag, got), int'(out_sb), e_sb);
          $display("[TB] %s out %0d grey %0d sb %0d cycle %0d", tag, got,
                   int'(out_grey), int'(out_sb), cyc);
        end
        got++;
        occ--;
      end
      if (in_valid && in_ready) begin
        exp_grey.push_back(model(int'(mode), 77, 150, 29,
                                 pix_r(sent), pix_g(sent), pix_b(sent)));
        exp_sb.push_back(int'(in_sb));
        sent++;
        occ++;
      end
      cyc++;
    end
    check({tag, "_count"}, got, n);
    if (!toggle) check({tag, "_cycles"}, cyc, n + 2);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check({tag, "_drained"}, int'(out_valid), 0);
    end
  endtask

  initial begin
    vec_t rv;
    vecs[0]  = '{0, 77, 150, 29, 255, 255, 255, 1, 255};
    vecs[1]  = '{0, 77, 150, 29, 100, 50, 200, 0, 82};
    vecs[2]  = '{1, 0, 0, 0, 255, 0, 0, 2, 54};
    vecs[3]  = '{2, 0, 0, 0, 30, 60, 90, 3, 60};
    vecs[4]  = '{3, 0, 0, 0, 1, 2, 3, 1, 2};
    vecs[5]  = '{0, 255, 255, 255, 255, 255, 255, 0, 255};
    vecs[6]  = '{1, 0, 0, 0, 0, 255, 0, 2, 182};
    vecs[7]  = '{2, 0, 0, 0, 255, 255, 255, 0, 254};
    vecs[8]  = '{0, 0, 0, 0, 255, 255, 255, 3, 0};
    vecs[9]  = '{1, 0, 0, 0, 0, 0, 255, 1, 19};
    vecs[10] = '{3, 9, 9, 9, 255, 0, 255, 2, 0};
    vecs[11] = '{0, 129, 128, 0, 255, 255, 0, 0, 255};
    vecs[12] = '{0, 128, 128, 0, 255, 254, 0, 1, 255};

    // Reset state.
    #2 rst_n = 1'b0;
    #20;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_grey", int'(out_grey), 0);
    check("reset_out_sb", int'(out_sb), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 13; i++) apply_one(i, vecs[i]);

    run_stream("backpressure", 10, 1'b1, 100);
    run_stream("mode_switch", 8, 1'b0, 4);

    // Two pixels stuck in the pipe, then asynchronous reset.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode      = 2'd3;
    in_r      = 8'd0;
    in_g      = 8'd10;
    in_b      = 8'd0;
    in_sb     = 2'b01;
    @(posedge clk); #1;
    in_g  = 8'd20;
    in_sb = 2'b10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", int'(out_valid), 1);
    check("full_out_grey", int'(out_grey), 10);
    check("full_in_ready", int'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out_grey", int'(out_grey), 0);
    check("arst_out_sb", int'(out_sb), 0);
    $display("[TB] async reset with 2 pixels in flight");
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_no_stale", int'(out_valid), 0);
    end
    rv = '{3, 0, 0, 0, 5, 77, 9, 1, 77};
    apply_one(13, rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
